// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM state encoding,
// request op encoding, default widths and the address range helper.
package mem_pkg;

   localparam int unsigned ADDR_W_DEF = 12;
   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      DONE  = 2'b10,
      FAULT = 2'b11
   } state_t;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   // Widened compare so shallow arrays behind a wide address bus are caught.
   function automatic logic addr_ok(input logic [31:0] a, input logic [31:0] depth);
      return a < depth;
   endfunction

endpackage

// File: rtl/mem_storage.sv
// DEPTH x DATA_W word array: one synchronous read/write access port driven by
// the responder FSM plus a write-only preload port.
module mem_storage
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 4096
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              acc_en,
   input  logic              acc_we,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [DATA_W-1:0] acc_wdata,
   output logic [DATA_W-1:0] acc_rdata,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              acc_ok;
   logic              ld_ok;

   assign acc_ok = addr_ok(32'(acc_addr), DEPTH);
   assign ld_ok  = addr_ok(32'(ld_addr), DEPTH);

   // The access-port write comes second so it overrides a same-address preload.
   always_ff @(posedge clock) begin
      if (ld_en && ld_ok)
         mem[ld_addr[IDX_W-1:0]] <= ld_data;
      if (acc_en && acc_we && acc_ok)
         mem[acc_addr[IDX_W-1:0]] <= acc_wdata;
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst)
         acc_rdata <= '0;
      else if (acc_en && !acc_we && acc_ok)
         acc_rdata <= mem[acc_addr[IDX_W-1:0]];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multi-cycle CPU: samples MemRead/MemWrite in
// IDLE, waits LATENCY cycles, then completes with a ready (or err) pulse.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned DEPTH   = 4096,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              busy,
   output logic              err,
   output logic [1:0]        dbg_state
);

   // Handshake: a request is accepted when exactly one strobe is high at a
   // rising edge while busy is low; it completes with a one-cycle ready (or
   // err) pulse, there is no response backpressure, and strobes seen while
   // busy are ignored.

   state_t            state;
   logic [3:0]        cnt;
   logic              op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              acc_en;

   // The array access happens on the edge that moves WAIT -> DONE.
   assign acc_en = (state == WAIT) && (cnt == 4'd0);

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         op_q    <= OP_RD;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (MemRead && MemWrite) begin
                  state <= FAULT;
               end else if (MemRead || MemWrite) begin
                  op_q    <= MemWrite ? OP_WR : OP_RD;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  cnt     <= 4'(LATENCY - 1);
                  state   <= addr_ok(32'(addr), DEPTH) ? WAIT : FAULT;
               end
            end
            WAIT: begin
               if (cnt == 4'd0)
                  state <= DONE;
               else
                  cnt <= cnt - 4'd1;
            end
            DONE:    state <= IDLE;
            FAULT:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign ready     = (state == DONE);
   assign err       = (state == FAULT);
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   mem_storage #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_storage (
      .clock     (clock),
      .rst       (rst),
      .acc_en    (acc_en),
      .acc_we    (op_q == OP_WR),
      .acc_addr  (addr_q),
      .acc_wdata (wdata_q),
      .acc_rdata (rdata),
      .ld_en     (load_en),
      .ld_addr   (load_addr),
      .ld_data   (load_data)
   );

endmodule
